gemm_os_systolic_top: RTL and testbench

Parametrised output-stationary systolic GeMM accelerator. It computes C = A x B on a NumRows x NumCols grid of signed MAC cells. Operands are streamed from SRAM A and SRAM B through skew registers, and results are drained to SRAM C one tile-row per cycle. The block sits between the testbench/system SRAMs and the host start/done interface, and loops over output tiles internally.

---
 rtl/gemm_os_systolic_top_if.sv | 40 ++++
 rtl/gemm_os_systolic_top.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_gemm_os_systolic_top.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_os_systolic_top_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gemm_os_systolic_top_if: host start/done and SRAM A/B/C ports        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gemm_os_systolic_top_if #(
  parameter int NumRows       = 4,
  parameter int NumCols       = 4,
  parameter int DataWidthI    = 8,
  parameter int DataWidthO    = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8
);
  logic                          start_i;
  logic [SizeAddrWidth-1:0]      M_tiles_i;
  logic [SizeAddrWidth-1:0]      K_size_i;
  logic [SizeAddrWidth-1:0]      N_tiles_i;
  logic [AddrWidth-1:0]          sram_a_addr_o;
  logic [AddrWidth-1:0]          sram_b_addr_o;
  logic [NumRows*DataWidthI-1:0] sram_a_rdata_i;
  logic [NumCols*DataWidthI-1:0] sram_b_rdata_i;
  logic [AddrWidth-1:0]          sram_c_addr_o;
  logic [NumCols*DataWidthO-1:0] sram_c_wdata_o;
  logic                          sram_c_we_o;
  logic                          busy_o;
  logic                          done_o;

  modport master (
    output start_i, M_tiles_i, K_size_i, N_tiles_i, sram_a_rdata_i, sram_b_rdata_i,
    input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
           busy_o, done_o
  );

  modport slave (
    input  start_i, M_tiles_i, K_size_i, N_tiles_i, sram_a_rdata_i, sram_b_rdata_i,
    output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
           busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/gemm_os_systolic_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gemm_os_systolic_top: output-stationary systolic GeMM, C = A x B     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gemm_os_systolic_top #(
  parameter int NumRows       = 4,
  parameter int NumCols       = 4,
  parameter int DataWidthI    = 8,
  parameter int DataWidthO    = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  gemm_os_systolic_top_if.slave bus
);

  localparam int c_flush_cycles = NumRows + NumCols - 1;
  localparam int c_fl_w         = $clog2(c_flush_cycles + 1);
  localparam int c_row_w        = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [c_fl_w-1:0]        c_fl_last  = c_fl_w'(c_flush_cycles - 1);
  localparam logic [c_fl_w-1:0]        c_fl_one   = c_fl_w'(1);
  localparam logic [c_row_w-1:0]       c_row_last = c_row_w'(NumRows - 1);
  localparam logic [c_row_w-1:0]       c_row_one  = c_row_w'(1);
  localparam logic [SizeAddrWidth-1:0] c_sz_one   = SizeAddrWidth'(1);
  localparam logic [AddrWidth-1:0]     c_addr_one = AddrWidth'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e                   r_state;
  logic [SizeAddrWidth-1:0] r_mt_n, r_k_n, r_nt_n, r_mt, r_nt, r_k;
  logic [c_fl_w-1:0]        r_fl;
  logic [c_row_w-1:0]       r_row;
  logic [AddrWidth-1:0]     r_a_base, r_b_base, r_c_base;
  logic [AddrWidth-1:0]     r_a_addr, r_b_addr, r_c_addr;
  logic                     r_we, r_busy, r_done, r_rd_valid;

  logic [AddrWidth-1:0] w_k_ext, w_nt_ext, w_tile_stride;
  logic                 w_zero_size, w_clr;

  assign w_k_ext       = AddrWidth'(r_k_n);
  assign w_nt_ext      = AddrWidth'(r_nt_n);
  assign w_tile_stride = w_nt_ext * AddrWidth'(NumRows);
  assign w_zero_size   = (bus.M_tiles_i == '0) || (bus.K_size_i == '0) || (bus.N_tiles_i == '0);
  assign w_clr         = (r_state == S_WRITE) && (r_row == c_row_last);

  assign bus.sram_a_addr_o = r_a_addr;
  assign bus.sram_b_addr_o = r_b_addr;
  assign bus.sram_c_addr_o = r_c_addr;
  assign bus.sram_c_we_o   = r_we;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_mt_n     <= '0;
      r_k_n      <= '0;
      r_nt_n     <= '0;
      r_mt       <= '0;
      r_nt       <= '0;
      r_k        <= '0;
      r_fl       <= '0;
      r_row      <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_c_base   <= '0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
      r_c_addr   <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      // SRAM data lags the FEED address by one cycle.
      r_rd_valid <= (r_state == S_FEED);
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_mt_n   <= bus.M_tiles_i;
            r_k_n    <= bus.K_size_i;
            r_nt_n   <= bus.N_tiles_i;
            r_mt     <= '0;
            r_nt     <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            if (w_zero_size) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_FEED;
              r_busy   <= 1'b1;
              r_a_addr <= '0;
              r_b_addr <= '0;
            end
          end
        end
        S_FEED: begin
          if (r_k == r_k_n - c_sz_one) begin
            r_state <= S_FLUSH;
            r_fl    <= '0;
          end else begin
            r_k      <= r_k + c_sz_one;
            r_a_addr <= r_a_addr + c_addr_one;
            r_b_addr <= r_b_addr + c_addr_one;
          end
        end
        S_FLUSH: begin
          if (r_fl == c_fl_last) begin
            r_state  <= S_WRITE;
            r_row    <= '0;
            r_we     <= 1'b1;
            r_c_addr <= r_c_base + AddrWidth'(r_nt);
          end else begin
            r_fl <= r_fl + c_fl_one;
          end
        end
        S_WRITE: begin
          if (r_row != c_row_last) begin
            r_row    <= r_row + c_row_one;
            r_c_addr <= r_c_addr + w_nt_ext;
          end else begin
            r_we <= 1'b0;
            r_k  <= '0;
            if (r_nt != r_nt_n - c_sz_one) begin
              r_nt     <= r_nt + c_sz_one;
              r_b_base <= r_b_base + w_k_ext;
              r_b_addr <= r_b_base + w_k_ext;
              r_a_addr <= r_a_base;
              r_state  <= S_FEED;
            end else if (r_mt != r_mt_n - c_sz_one) begin
              r_nt     <= '0;
              r_mt     <= r_mt + c_sz_one;
              r_b_base <= '0;
              r_b_addr <= '0;
              r_a_base <= r_a_base + w_k_ext;
              r_a_addr <= r_a_base + w_k_ext;
              r_c_base <= r_c_base + w_tile_stride;
              r_state  <= S_FEED;
            end else begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic signed [DataWidthI-1:0] w_west_a  [NumRows];
  logic                         w_west_v  [NumRows];
  logic signed [DataWidthI-1:0] w_north_b [NumCols];
  logic                         w_north_v [NumCols];
  logic signed [DataWidthO-1:0] w_acc     [NumRows][NumCols];

  // Lane i is delayed i cycles so operands of equal k meet diagonally.
  for (genvar r = 0; r < NumRows; r++) begin : g_skew_a
    if (r == 0) begin : g_direct
      assign w_west_a[r] = bus.sram_a_rdata_i[r*DataWidthI +: DataWidthI];
      assign w_west_v[r] = r_rd_valid;
    end else begin : g_delay
      logic signed [DataWidthI-1:0] r_sd [r];
      logic                         r_sv [r];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < r; i++) begin
            r_sd[i] <= '0;
            r_sv[i] <= 1'b0;
          end
        end else begin
          r_sd[0] <= bus.sram_a_rdata_i[r*DataWidthI +: DataWidthI];
          r_sv[0] <= r_rd_valid;
          for (int i = 1; i < r; i++) begin
            r_sd[i] <= r_sd[i-1];
            r_sv[i] <= r_sv[i-1];
          end
        end
      end
      assign w_west_a[r] = r_sd[r-1];
      assign w_west_v[r] = r_sv[r-1];
    end
  end

  for (genvar c = 0; c < NumCols; c++) begin : g_skew_b
    if (c == 0) begin : g_direct
      assign w_north_b[c] = bus.sram_b_rdata_i[c*DataWidthI +: DataWidthI];
      assign w_north_v[c] = r_rd_valid;
    end else begin : g_delay
      logic signed [DataWidthI-1:0] r_sd [c];
      logic                         r_sv [c];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < c; i++) begin
            r_sd[i] <= '0;
            r_sv[i] <= 1'b0;
          end
        end else begin
          r_sd[0] <= bus.sram_b_rdata_i[c*DataWidthI +: DataWidthI];
          r_sv[0] <= r_rd_valid;
          for (int i = 1; i < c; i++) begin
            r_sd[i] <= r_sd[i-1];
            r_sv[i] <= r_sv[i-1];
          end
        end
      end
      assign w_north_b[c] = r_sd[c-1];
      assign w_north_v[c] = r_sv[c-1];
    end
  end

  // Each cell consumes its inputs in the cycle they arrive and forwards them registered.
  for (genvar r = 0; r < NumRows; r++) begin : g_row
    for (genvar c = 0; c < NumCols; c++) begin : g_col
      logic signed [DataWidthI-1:0]   w_a_in, w_b_in;
      logic                           w_av_in, w_bv_in;
      logic signed [2*DataWidthI-1:0] w_prod;
      logic signed [DataWidthO-1:0]   r_acc;

      if (c == 0) begin : g_a_edge
        assign w_a_in  = w_west_a[r];
        assign w_av_in = w_west_v[r];
      end else begin : g_a_link
        assign w_a_in  = g_row[r].g_col[c-1].g_fwd_a.r_a_q;
        assign w_av_in = g_row[r].g_col[c-1].g_fwd_a.r_av_q;
      end

      if (r == 0) begin : g_b_edge
        assign w_b_in  = w_north_b[c];
        assign w_bv_in = w_north_v[c];
      end else begin : g_b_link
        assign w_b_in  = g_row[r-1].g_col[c].g_fwd_b.r_b_q;
        assign w_bv_in = g_row[r-1].g_col[c].g_fwd_b.r_bv_q;
      end

      if (c < NumCols - 1) begin : g_fwd_a
        logic signed [DataWidthI-1:0] r_a_q;
        logic                         r_av_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_a_q  <= '0;
            r_av_q <= 1'b0;
          end else begin
            r_a_q  <= w_a_in;
            r_av_q <= w_av_in;
          end
        end
      end

      if (r < NumRows - 1) begin : g_fwd_b
        logic signed [DataWidthI-1:0] r_b_q;
        logic                         r_bv_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_b_q  <= '0;
            r_bv_q <= 1'b0;
          end else begin
            r_b_q  <= w_b_in;
            r_bv_q <= w_bv_in;
          end
        end
      end

      assign w_prod = w_a_in * w_b_in;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_acc <= '0;
        end else if (w_clr) begin
          r_acc <= '0;
        end else if (w_av_in && w_bv_in) begin
          r_acc <= r_acc + DataWidthO'(w_prod);
        end
      end

      assign w_acc[r][c] = r_acc;
    end
  end

  for (genvar c = 0; c < NumCols; c++) begin : g_wdata
    assign bus.sram_c_wdata_o[c*DataWidthO +: DataWidthO] = w_acc[r_row][c];
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_os_systolic_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gemm_os_systolic_top: directed bench with a matrix-product model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gemm_os_systolic_top;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int DWI = 8;
  localparam int DWO = 32;
  localparam int AW  = 16;
  localparam int SW  = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  gemm_os_systolic_top_if #(.NumRows(R), .NumCols(C), .DataWidthI(DWI), .DataWidthO(DWO),
                            .AddrWidth(AW), .SizeAddrWidth(SW)) bus ();
  gemm_os_systolic_top_if #(.NumRows(R), .NumCols(C), .DataWidthI(DWI), .DataWidthO(16),
                            .AddrWidth(AW), .SizeAddrWidth(SW)) bus2 ();

  gemm_os_systolic_top #(.NumRows(R), .NumCols(C), .DataWidthI(DWI), .DataWidthO(DWO),
                         .AddrWidth(AW), .SizeAddrWidth(SW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  gemm_os_systolic_top #(.NumRows(R), .NumCols(C), .DataWidthI(DWI), .DataWidthO(16),
                         .AddrWidth(AW), .SizeAddrWidth(SW)) dut16 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus2)
  );

  logic [R*DWI-1:0] mem_a [256];
  logic [C*DWI-1:0] mem_b [256];

  always_ff @(posedge clk_i) begin
    bus.sram_a_rdata_i  <= mem_a[bus.sram_a_addr_o[7:0]];
    bus.sram_b_rdata_i  <= mem_b[bus.sram_b_addr_o[7:0]];
    bus2.sram_a_rdata_i <= mem_a[bus2.sram_a_addr_o[7:0]];
    bus2.sram_b_rdata_i <= mem_b[bus2.sram_b_addr_o[7:0]];
  end

  int mat_a [8][8];
  int mat_b [8][8];
  logic [AW-1:0]    exp_addr [$];
  logic [C*DWO-1:0] exp_data [$];

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;
  int last_we_cyc = 0;
  int n_wr  = 0;
  int n_wr2 = 0;

  always @(posedge clk_i) cyc_g++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every C write is checked, in order, against the model's queue.
  always @(negedge clk_i) begin
    if (bus.sram_c_we_o === 1'b1) begin
      n_wr++;
      last_we_cyc = cyc_g;
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d with no write expected", bus.sram_c_addr_o);
      end else begin
        check("c_addr", bus.sram_c_addr_o, exp_addr.pop_front());
        check("c_wdata", bus.sram_c_wdata_o, exp_data.pop_front());
      end
    end
    if (bus2.sram_c_we_o === 1'b1) begin
      n_wr2++;
      check("wrap16_wdata", bus2.sram_c_wdata_o, {4{16'h8000}});
    end
  end

  task automatic build(input int mt_n, input int k_n, input int nt_n);
    int v;
    int s;
    logic [C*DWO-1:0] d;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int t = 0; t < mt_n; t++)
      for (int k = 0; k < k_n; k++)
        for (int r = 0; r < R; r++) begin
          v = mat_a[t*R+r][k];
          mem_a[t*k_n+k][r*DWI +: DWI] = v[DWI-1:0];
        end
    for (int t = 0; t < nt_n; t++)
      for (int k = 0; k < k_n; k++)
        for (int c = 0; c < C; c++) begin
          v = mat_b[k][t*C+c];
          mem_b[t*k_n+k][c*DWI +: DWI] = v[DWI-1:0];
        end
    for (int mt = 0; mt < mt_n; mt++)
      for (int nt = 0; nt < nt_n; nt++)
        for (int r = 0; r < R; r++) begin
          for (int c = 0; c < C; c++) begin
            s = 0;
            for (int k = 0; k < k_n; k++) s += mat_a[mt*R+r][k] * mat_b[k][nt*C+c];
            d[c*DWO +: DWO] = s;
          end
          exp_addr.push_back(AW'((mt*R + r)*nt_n + nt));
          exp_data.push_back(d);
        end
  endtask

  task automatic run_op(input int mt_n, input int k_n, input int nt_n, input int n_exp,
                        input bit glitch, input bit chk_lat);
    int cyc;
    int busy_cnt;
    n_wr     = 0;
    busy_cnt = 0;
    bus.M_tiles_i = SW'(mt_n);
    bus.K_size_i  = SW'(k_n);
    bus.N_tiles_i = SW'(nt_n);
    bus.start_i   = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    cyc = 0;
    while (bus.done_o !== 1'b1 && cyc < 3000) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (glitch && cyc == 2) begin
        bus.start_i   = 1'b1;
        bus.M_tiles_i = 8'd2;
        bus.K_size_i  = 8'd3;
        bus.N_tiles_i = 8'd2;
      end else if (glitch && cyc == 3) begin
        bus.start_i = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    if (bus.done_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
    end else begin
      check("busy_at_done", bus.busy_o, 0);
      check("write_count", n_wr, n_exp);
      check("model_drained", exp_addr.size(), 0);
      if (chk_lat) begin
        check("busy_cycles", busy_cnt, 15);
        check("done_after_last_we", cyc_g - last_we_cyc, 1);
      end
      @(negedge clk_i);
      check("done_pulse_width", bus.done_o, 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = int'($urandom_range(255)) - 128;
        mat_b[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  int order [16] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
  logic [C*DWO-1:0] pin;

  initial begin
    bus.start_i = 1'b0;   bus.M_tiles_i = '0;  bus.K_size_i = '0;  bus.N_tiles_i = '0;
    bus2.start_i = 1'b0;  bus2.M_tiles_i = '0; bus2.K_size_i = '0; bus2.N_tiles_i = '0;
    #2 rst_ni = 1'b0;
    #1 check("reset_outputs",
             {bus.sram_a_addr_o, bus.sram_b_addr_o, bus.sram_c_addr_o, bus.sram_c_we_o,
              bus.busy_o, bus.done_o}, 0);
    check("reset_wdata", bus.sram_c_wdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Identity A: each C row equals the matching B row.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = (i == j) ? 1 : 0;
        mat_b[i][j] = i*4 + j;
      end
    build(1, 4, 1);
    pin = exp_data[1];
    check("pin_identity_row1", pin, {32'd7, 32'd6, 32'd5, 32'd4});
    run_op(1, 4, 1, 4, 1'b0, 1'b1);

    fill_random();
    build(2, 3, 2);
    for (int i = 0; i < 16; i++) check("pin_addr_order", exp_addr[i], AW'(order[i]));
    run_op(2, 3, 2, 16, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = -128;
        mat_b[i][j] = -128;
      end
    build(1, 4, 1);
    pin = exp_data[3];
    check("pin_minval_65536", pin, {4{32'd65536}});
    run_op(1, 4, 1, 4, 1'b0, 1'b1);

    // Same operands, 16-bit accumulators, K=2: 32768 wraps to -32768.
    n_wr2 = 0;
    bus2.M_tiles_i = 8'd1;
    bus2.K_size_i  = 8'd2;
    bus2.N_tiles_i = 8'd1;
    bus2.start_i   = 1'b1;
    @(negedge clk_i);
    bus2.start_i = 1'b0;
    for (int i = 0; i < 200 && bus2.done_o !== 1'b1; i++) @(negedge clk_i);
    check("wrap16_done", bus2.done_o, 1);
    check("wrap16_writes", n_wr2, 4);
    @(negedge clk_i);

    exp_addr.delete();
    exp_data.delete();
    run_op(1, 0, 1, 0, 1'b0, 1'b0);
    run_op(0, 4, 1, 0, 1'b0, 1'b0);

    fill_random();
    build(1, 4, 1);
    run_op(1, 4, 1, 4, 1'b1, 1'b0);

    // Abort in FLUSH, then rerun from cleared state.
    fill_random();
    build(1, 4, 1);
    n_wr = 0;
    bus.M_tiles_i = 8'd1;
    bus.K_size_i  = 8'd4;
    bus.N_tiles_i = 8'd1;
    bus.start_i   = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk_i);
    rst_ni = 1'b0;
    #1 check("async_reset_outputs",
             {bus.sram_a_addr_o, bus.sram_b_addr_o, bus.sram_c_addr_o, bus.sram_c_we_o,
              bus.busy_o, bus.done_o}, 0);
    check("async_reset_wdata", bus.sram_c_wdata_o, 0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("no_write_after_abort", n_wr, 0);
    build(1, 4, 1);
    run_op(1, 4, 1, 4, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
